// File: rtl/lsu_stbuf_q.sv
// Committed-store buffer feeding the DCCM/PIC port. Retired stores are held in age order.
// The oldest entry is offered as the write request, and the buffer also supplies byte-wise store-to-load forwarding.
module lsu_stbuf_q #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int ECC_W  = 7
) (
    input  logic                clk,
    input  logic                rst_l,

    input  logic                enq_vld,
    input  logic [ADDR_W-1:0]   enq_addr,
    input  logic [DATA_W-1:0]   enq_data,
    input  logic [ECC_W-1:0]    enq_ecc,
    input  logic [DATA_W/8-1:0] enq_byteen,
    input  logic                enq_pic,

    output logic                stbuf_reqvld_any,
    output logic [ADDR_W-1:0]   stbuf_addr_any,
    output logic [DATA_W-1:0]   stbuf_data_any,
    output logic [ECC_W-1:0]    stbuf_ecc_any,
    output logic                stbuf_addr_in_pic_any,
    input  logic                lsu_stbuf_commit_any,

    input  logic                ld_fwd_vld,
    input  logic [ADDR_W-1:0]   ld_fwd_addr,
    output logic [DATA_W/8-1:0] stbuf_fwdbyteen_lo_dc3,
    output logic [DATA_W-1:0]   stbuf_fwddata_lo_dc3,

    output logic                stbuf_full,
    output logic                stbuf_empty,
    output logic                stbuf_ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW:0]       count;
    logic [DEPTH-1:0]  valid_q;

    logic [ADDR_W-1:0] addr_q   [DEPTH];
    logic [DATA_W-1:0] data_q   [DEPTH];
    logic [ECC_W-1:0]  ecc_q    [DEPTH];
    logic [NB-1:0]     byteen_q [DEPTH];
    logic              pic_q    [DEPTH];

    logic              do_enq;
    logic              do_deq;
    logic [NB-1:0]     fwd_mask_d;
    logic [DATA_W-1:0] fwd_data_d;
    logic              ld_addr_unused;

    // Full/empty come from count alone; equal pointers mean either state.
    assign stbuf_empty      = (count == '0);
    assign stbuf_full       = (count == CNT_FULL);
    assign stbuf_reqvld_any = ~stbuf_empty;

    assign do_enq = enq_vld & ~stbuf_full;
    assign do_deq = lsu_stbuf_commit_any & ~stbuf_empty;

    assign stbuf_addr_any        = stbuf_empty ? '0   : addr_q[rd_ptr];
    assign stbuf_data_any        = stbuf_empty ? '0   : data_q[rd_ptr];
    assign stbuf_ecc_any         = stbuf_empty ? '0   : ecc_q[rd_ptr];
    assign stbuf_addr_in_pic_any = stbuf_empty ? 1'b0 : pic_q[rd_ptr];

    // Forwarding only looks at the word address.
    assign ld_addr_unused = ^ld_fwd_addr[1:0];

    function automatic logic [PW-1:0] age_idx(input logic [PW-1:0] base, input int off);
        logic [PW-1:0] step;
        step = off[PW-1:0];
        return base + step;
    endfunction

    // Walk the entries oldest to youngest so younger matches overwrite older ones.
    // An entry enqueued this cycle is not yet valid, so it is never seen here.
    always_comb begin
        fwd_mask_d = '0;
        fwd_data_d = '0;
        if (ld_fwd_vld) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (valid_q[age_idx(rd_ptr, i)] &&
                        (addr_q[age_idx(rd_ptr, i)][ADDR_W-1:2] == ld_fwd_addr[ADDR_W-1:2]) &&
                        byteen_q[age_idx(rd_ptr, i)][b]) begin
                        fwd_mask_d[b]          = 1'b1;
                        fwd_data_d[b*8 +: 8]   = data_q[age_idx(rd_ptr, i)][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            valid_q       <= '0;
            stbuf_ovf_err <= 1'b0;
        end else begin
            if (do_deq) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (do_enq) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (enq_vld && stbuf_full) begin
                stbuf_ovf_err <= 1'b1;
            end
        end
    end

    // Payload needs no reset: head outputs are gated by empty and lookups by valid.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_q[wr_ptr]   <= enq_addr;
            data_q[wr_ptr]   <= enq_data;
            ecc_q[wr_ptr]    <= enq_ecc;
            byteen_q[wr_ptr] <= enq_byteen;
            pic_q[wr_ptr]    <= enq_pic;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stbuf_fwdbyteen_lo_dc3 <= '0;
            stbuf_fwddata_lo_dc3   <= '0;
        end else begin
            stbuf_fwdbyteen_lo_dc3 <= fwd_mask_d;
            stbuf_fwddata_lo_dc3   <= fwd_data_d;
        end
    end

endmodule

// File: tb/tb_lsu_stbuf_q.sv
// Self-checking bench for lsu_stbuf_q: vector table, directed wrap/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_lsu_stbuf_q;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        enq_vld;
    logic [15:0] enq_addr;
    logic [31:0] enq_data;
    logic [6:0]  enq_ecc;
    logic [3:0]  enq_byteen;
    logic        enq_pic;
    logic        stbuf_reqvld_any;
    logic [15:0] stbuf_addr_any;
    logic [31:0] stbuf_data_any;
    logic [6:0]  stbuf_ecc_any;
    logic        stbuf_addr_in_pic_any;
    logic        lsu_stbuf_commit_any;
    logic        ld_fwd_vld;
    logic [15:0] ld_fwd_addr;
    logic [3:0]  stbuf_fwdbyteen_lo_dc3;
    logic [31:0] stbuf_fwddata_lo_dc3;
    logic        stbuf_full;
    logic        stbuf_empty;
    logic        stbuf_ovf_err;

    lsu_stbuf_q #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32), .ECC_W(7)) dut (
        .clk                    (clk),
        .rst_l                  (rst_l),
        .enq_vld                (enq_vld),
        .enq_addr               (enq_addr),
        .enq_data               (enq_data),
        .enq_ecc                (enq_ecc),
        .enq_byteen             (enq_byteen),
        .enq_pic                (enq_pic),
        .stbuf_reqvld_any       (stbuf_reqvld_any),
        .stbuf_addr_any         (stbuf_addr_any),
        .stbuf_data_any         (stbuf_data_any),
        .stbuf_ecc_any          (stbuf_ecc_any),
        .stbuf_addr_in_pic_any  (stbuf_addr_in_pic_any),
        .lsu_stbuf_commit_any   (lsu_stbuf_commit_any),
        .ld_fwd_vld             (ld_fwd_vld),
        .ld_fwd_addr            (ld_fwd_addr),
        .stbuf_fwdbyteen_lo_dc3 (stbuf_fwdbyteen_lo_dc3),
        .stbuf_fwddata_lo_dc3   (stbuf_fwddata_lo_dc3),
        .stbuf_full             (stbuf_full),
        .stbuf_empty            (stbuf_empty),
        .stbuf_ovf_err          (stbuf_ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [6:0]  ecc;
        logic [3:0]  be;
        logic        pic;
    } ent_t;

    typedef struct {
        logic        e_vld;
        logic [15:0] e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic        cmt;
        logic        l_vld;
        logic [15:0] l_addr;
        logic        x_req;
        logic [15:0] x_addr;
        logic [31:0] x_data;
        logic        x_full;
        logic        x_empty;
        logic        x_ovf;
        logic [3:0]  x_mask;
        logic [31:0] x_fdata;
    } vec_t;

    ent_t        mq[$];
    logic        m_ovf;
    logic [3:0]  m_mask;
    logic [31:0] m_fdata;
    int          n_vec = 0;
    int          n_err = 0;
    int          step_no = 0;
    vec_t        tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_mask  = '0;
        m_fdata = '0;
    endtask

    task automatic chk_model();
        ent_t h;
        h = '{default: '0};
        if (mq.size() > 0) h = mq[0];
        chk("reqvld", stbuf_reqvld_any, mq.size() > 0);
        chk("head_addr", stbuf_addr_any, h.addr);
        chk("head_data", stbuf_data_any, h.data);
        chk("head_ecc", stbuf_ecc_any, h.ecc);
        chk("head_pic", stbuf_addr_in_pic_any, h.pic);
        chk("full", stbuf_full, mq.size() == DEPTH);
        chk("empty", stbuf_empty, mq.size() == 0);
        chk("ovf_err", stbuf_ovf_err, m_ovf);
        chk("fwd_mask", stbuf_fwdbyteen_lo_dc3, m_mask);
        chk("fwd_data", stbuf_fwddata_lo_dc3, m_fdata);
    endtask

    // Called at a negedge; drives one cycle, advances the model, checks at the next negedge.
    task automatic step(input logic e_vld, input logic [15:0] e_addr, input logic [31:0] e_data,
                        input logic [6:0] e_ecc, input logic [3:0] e_be, input logic e_pic,
                        input logic cmt, input logic l_vld, input logic [15:0] l_addr);
        logic was_full;
        ent_t e;
        enq_vld = e_vld; enq_addr = e_addr; enq_data = e_data; enq_ecc = e_ecc;
        enq_byteen = e_be; enq_pic = e_pic;
        lsu_stbuf_commit_any = cmt; ld_fwd_vld = l_vld; ld_fwd_addr = l_addr;

        m_mask  = '0;
        m_fdata = '0;
        if (l_vld) begin
            foreach (mq[i]) begin
                if (mq[i].addr[15:2] == l_addr[15:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mq[i].be[b]) begin
                            m_mask[b]         = 1'b1;
                            m_fdata[b*8 +: 8] = mq[i].data[b*8 +: 8];
                        end
                    end
                end
            end
        end
        was_full = (mq.size() == DEPTH);
        if (cmt && mq.size() > 0) void'(mq.pop_front());
        if (e_vld) begin
            if (was_full) m_ovf = 1'b1;
            else begin
                e = '{addr: e_addr, data: e_data, ecc: e_ecc, be: e_be, pic: e_pic};
                mq.push_back(e);
            end
        end

        @(posedge clk);
        @(negedge clk);
        step_no++;
        chk_model();
    endtask

    task automatic idle(input logic cmt);
        step(1'b0, '0, '0, '0, '0, 1'b0, cmt, 1'b0, '0);
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] d;

        rst_l = 1'b0;
        enq_vld = 0; enq_addr = 0; enq_data = 0; enq_ecc = 0; enq_byteen = 0; enq_pic = 0;
        lsu_stbuf_commit_any = 0; ld_fwd_vld = 0; ld_fwd_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_reqvld", stbuf_reqvld_any, 0);
        chk("rst_empty", stbuf_empty, 1);
        chk("rst_full", stbuf_full, 0);
        chk("rst_ovf", stbuf_ovf_err, 0);
        chk("rst_fwd_mask", stbuf_fwdbyteen_lo_dc3, 0);
        chk("rst_head_addr", stbuf_addr_any, 0);
        rst_l = 1'b1;
        @(negedge clk);

        // e_vld addr data be cmt l_vld l_addr | req addr data full empty ovf mask fdata
        tbl[0]  = '{1, 16'h0010, 32'h11223344, 4'hF, 0, 0, 16'h0000, 1, 16'h0010, 32'h11223344, 0, 0, 0, 4'h0, 32'h0};
        tbl[1]  = '{1, 16'h0014, 32'h55667788, 4'hF, 0, 0, 16'h0000, 1, 16'h0010, 32'h11223344, 0, 0, 0, 4'h0, 32'h0};
        tbl[2]  = '{1, 16'h0018, 32'h99AABBCC, 4'h3, 0, 1, 16'h0012, 1, 16'h0010, 32'h11223344, 0, 0, 0, 4'hF, 32'h11223344};
        tbl[3]  = '{1, 16'h001C, 32'hDDEEFF00, 4'hF, 0, 1, 16'h0018, 1, 16'h0010, 32'h11223344, 1, 0, 0, 4'h3, 32'h0000BBCC};
        tbl[4]  = '{1, 16'h0030, 32'hCAFEF00D, 4'hF, 0, 0, 16'h0000, 1, 16'h0010, 32'h11223344, 1, 0, 1, 4'h0, 32'h0};
        tbl[5]  = '{1, 16'h0040, 32'h12345678, 4'hF, 1, 1, 16'h0010, 1, 16'h0014, 32'h55667788, 0, 0, 1, 4'hF, 32'h11223344};
        tbl[6]  = '{0, 16'h0000, 32'h0,        4'h0, 1, 0, 16'h0000, 1, 16'h0018, 32'h99AABBCC, 0, 0, 1, 4'h0, 32'h0};
        tbl[7]  = '{0, 16'h0000, 32'h0,        4'h0, 1, 0, 16'h0000, 1, 16'h001C, 32'hDDEEFF00, 0, 0, 1, 4'h0, 32'h0};
        tbl[8]  = '{0, 16'h0000, 32'h0,        4'h0, 1, 0, 16'h0000, 0, 16'h0000, 32'h0,        0, 1, 1, 4'h0, 32'h0};
        tbl[9]  = '{0, 16'h0000, 32'h0,        4'h0, 1, 0, 16'h0000, 0, 16'h0000, 32'h0,        0, 1, 1, 4'h0, 32'h0};
        tbl[10] = '{1, 16'h0020, 32'hAAAAAAAA, 4'hF, 0, 0, 16'h0000, 1, 16'h0020, 32'hAAAAAAAA, 0, 0, 1, 4'h0, 32'h0};
        tbl[11] = '{1, 16'h0020, 32'h0000BB00, 4'h2, 0, 0, 16'h0000, 1, 16'h0020, 32'hAAAAAAAA, 0, 0, 1, 4'h0, 32'h0};
        tbl[12] = '{0, 16'h0000, 32'h0,        4'h0, 0, 1, 16'h0022, 1, 16'h0020, 32'hAAAAAAAA, 0, 0, 1, 4'hF, 32'hAAAABBAA};
        tbl[13] = '{0, 16'h0000, 32'h0,        4'h0, 1, 1, 16'h0022, 1, 16'h0020, 32'h0000BB00, 0, 0, 1, 4'hF, 32'hAAAABBAA};
        tbl[14] = '{0, 16'h0000, 32'h0,        4'h0, 0, 1, 16'h0022, 1, 16'h0020, 32'h0000BB00, 0, 0, 1, 4'h2, 32'h0000BB00};
        tbl[15] = '{0, 16'h0000, 32'h0,        4'h0, 1, 1, 16'h0024, 0, 16'h0000, 32'h0,        0, 1, 1, 4'h0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].e_vld, tbl[i].e_addr, tbl[i].e_data, tbl[i].e_data[6:0] ^ 7'h55,
                 tbl[i].e_be, tbl[i].e_addr[5], tbl[i].cmt, tbl[i].l_vld, tbl[i].l_addr);
            chk("tbl_reqvld", stbuf_reqvld_any, tbl[i].x_req);
            chk("tbl_addr", stbuf_addr_any, tbl[i].x_addr);
            chk("tbl_data", stbuf_data_any, tbl[i].x_data);
            chk("tbl_full", stbuf_full, tbl[i].x_full);
            chk("tbl_empty", stbuf_empty, tbl[i].x_empty);
            chk("tbl_ovf", stbuf_ovf_err, tbl[i].x_ovf);
            chk("tbl_fwd_mask", stbuf_fwdbyteen_lo_dc3, tbl[i].x_mask);
            chk("tbl_fwd_data", stbuf_fwddata_lo_dc3, tbl[i].x_fdata);
        end

        // Enqueue plus commit every cycle: pointers wrap, head always the previous store.
        for (int k = 0; k < 10; k++) begin
            a = 16'h0100 + 16'(4 * k);
            step(1'b1, a, {16'hC0DE, a}, 7'(k), 4'hF, 1'b0, 1'b1, 1'b0, '0);
            chk("wrap_head", stbuf_addr_any, a);
            chk("wrap_count1", {stbuf_full, stbuf_empty}, 2'b00);
        end
        idle(1'b1);
        chk("wrap_drained", stbuf_empty, 1);

        for (int k = 0; k < 400; k++) begin
            a = 16'h0040 + 16'(4 * $urandom_range(0, 3));
            d = $urandom;
            step($urandom_range(0, 9) < 6, a, d, 7'($urandom), 4'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 4, 1'($urandom), 16'h0040 + 16'($urandom_range(0, 19)));
        end

        // Mid-stream reset discards everything immediately.
        idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b1);
        step(1'b1, 16'h0200, 32'h01020304, 7'h11, 4'hF, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 16'h0204, 32'h05060708, 7'h22, 4'hF, 1'b1, 1'b0, 1'b1, 16'h0200);
        chk("pre_rst_mask", stbuf_fwdbyteen_lo_dc3, 4'hF);
        rst_l = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_reqvld", stbuf_reqvld_any, 0);
        chk("mid_rst_empty", stbuf_empty, 1);
        chk("mid_rst_fwd_mask", stbuf_fwdbyteen_lo_dc3, 0);
        chk("mid_rst_fwd_data", stbuf_fwddata_lo_dc3, 0);
        chk("mid_rst_ovf", stbuf_ovf_err, 0);
        @(negedge clk);
        rst_l = 1'b1;
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("post_rst_noreq", stbuf_reqvld_any, 0);
        step(1'b1, 16'h0300, 32'hFEEDBEEF, 7'h33, 4'hF, 1'b1, 1'b0, 1'b0, '0);
        chk("post_rst_req", stbuf_reqvld_any, 1);
        chk("post_rst_addr", stbuf_addr_any, 16'h0300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_stbuf_q.md
Name: lsu_stbuf_q

Overview:
- Committed-store buffer sitting directly upstream of the DCCM/PIC port controller.
- Holds retired stores (address, merged data, ECC, byte enables, PIC flag) in age order.
- Presents the oldest entry as the store-buffer write request and pops it when the port controller grants the commit.
- Supplies byte-granular store-to-load forwarding data for the lower word of in-flight loads.

Parameters:
DEPTH, 4, number of entries; power of two, 2..8
ADDR_W, 16, store-buffer address width (matches RV_LSU_SB_BITS)
DATA_W, 32, data width (matches RV_DCCM_DATA_WIDTH)
ECC_W, 7, ECC width (matches RV_DCCM_ECC_WIDTH)

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
enq_vld  in  1  store retired at DC4; enqueue this cycle
enq_addr  in  ADDR_W  store byte address, word aligned
enq_data  in  DATA_W  merged full-word store data
enq_ecc  in  ECC_W  ECC of enq_data
enq_byteen  in  DATA_W/8  bytes actually written by the store
enq_pic  in  1  store targets PIC
stbuf_reqvld_any  out  1  head entry valid
stbuf_addr_any  out  ADDR_W  head address
stbuf_data_any  out  DATA_W  head data
stbuf_ecc_any  out  ECC_W  head ECC
stbuf_addr_in_pic_any  out  1  head PIC flag
lsu_stbuf_commit_any  in  1  port controller accepted head; pop
ld_fwd_vld  in  1  load lookup in DC2
ld_fwd_addr  in  ADDR_W  load byte address
stbuf_fwdbyteen_lo_dc3  out  DATA_W/8  forwarded byte mask, DC3
stbuf_fwddata_lo_dc3  out  DATA_W  forwarded data, DC3
stbuf_full  out  1  all entries valid
stbuf_empty  out  1  no entries valid
stbuf_ovf_err  out  1  sticky: enqueue attempted while full

Behaviour:
- Storage: circular queue; rd_ptr, wr_ptr of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; per-entry valid bit.
- Reset (async, rst_l low): pointers 0, count 0, all valid bits 0, stbuf_ovf_err 0, forward outputs 0. Outputs: reqvld 0, empty 1, full 0; head fields 0.
- Head outputs are combinational from the entry at rd_ptr, gated to 0 when the buffer is empty. stbuf_reqvld_any = ~stbuf_empty.
- Enqueue: when enq_vld & ~stbuf_full, write the entry at wr_ptr, set its valid bit, and increment wr_ptr (wraps mod DEPTH). The entry is visible as head on the next cycle at the earliest.
- Dequeue: when lsu_stbuf_commit_any & stbuf_reqvld_any, clear the valid bit at rd_ptr and increment rd_ptr (wraps). A commit while empty is ignored.
- Simultaneous enqueue and dequeue: both happen and count is unchanged. If the buffer is full, the enqueue is still rejected even if a pop occurs the same cycle; the full check uses pre-pop state.
- Overflow: enq_vld & stbuf_full drops the store and sets stbuf_ovf_err. The flag clears only on reset.
- Forwarding lookup (DC2):
  - An entry matches when it is valid and its addr[ADDR_W-1:2] equals ld_fwd_addr[ADDR_W-1:2].
  - For each byte b, the youngest matching entry whose byteen[b]=1 supplies data byte b. Age is measured from rd_ptr.
  - An entry being enqueued this cycle is excluded from the lookup.
  - An entry being popped this cycle is included.
- Forwarding outputs are registered, giving one cycle of latency into DC3. The mask is 0 when ld_fwd_vld is 0 or there is no match. Data bytes whose mask bit is 0 are 0.
- Wrap-around: pointer equality alone is ambiguous, so full/empty are derived from count only.
- Mid-operation reset: all queued stores are discarded; no commit request is issued after rst_l deasserts until a new enqueue.

Test Plan:
- Reset, then enqueue A=0x0010 / D=0x11223344 / byteen=0xF; no commit -> next cycle reqvld=1, addr=0x0010, data=0x11223344, empty=0.
- Enqueue 4 stores, commit held 0 -> full=1. A 5th enq_vld -> dropped, ovf_err=1. Then commit 4 times -> addresses pop in enqueue order and empty=1.
- Full buffer, enq_vld and commit in the same cycle -> pop occurs, enqueue rejected, count=3, ovf_err=1.
- Steady enqueue plus commit every cycle for 10 cycles -> pointers wrap and the FIFO order is preserved across the wrap. count never exceeds 1 after the first cycle.
- Two stores to 0x0020: older byteen=0xF, D=0xAAAAAAAA; younger byteen=0x2, D=0x0000BB00. Load lookup at 0x0022 -> next cycle fwdbyteen=0xF, fwddata=0xAAAABBAA.
- Entries queued, rst_l pulsed low mid-stream -> reqvld=0, empty=1, fwdbyteen=0 immediately. No request appears after release until the next enqueue.
